// File: rtl/laser_pkg.sv
// Shared types and constants for the laser target feeder.
// Holds point-count, radius, timeout constants, state enums and the distance helper.
package laser_pkg;

    localparam int NPTS = 40;
    localparam logic [5:0] LAST_IDX = 6'(NPTS - 1);
    localparam logic [8:0] RADIUS_SQ = 9'd16;
    localparam logic [9:0] TIMEOUT = 10'd1023;

    typedef logic [3:0] coord_t;

    typedef enum logic [1:0] {
        B_FREE,
        B_READY,
        B_STREAMING,
        B_SCORING
    } bank_st_t;

    typedef enum logic [1:0] {
        S_HOLD,
        S_STREAM,
        S_WAIT
    } strm_st_t;

    // Exact squared distance; |d| never exceeds 15 so 9 bits hold the sum.
    function automatic logic [8:0] dist_sq(
        input coord_t ax,
        input coord_t ay,
        input coord_t bx,
        input coord_t by
    );
        logic signed [4:0] dx, dy, nx, ny;
        logic [3:0] mx, my;
        logic [7:0] sx, sy;
        dx = $signed({1'b0, ax}) - $signed({1'b0, bx});
        dy = $signed({1'b0, ay}) - $signed({1'b0, by});
        nx = -dx;
        ny = -dy;
        mx = dx[4] ? nx[3:0] : dx[3:0];
        my = dy[4] ? ny[3:0] : dy[3:0];
        sx = {4'd0, mx} * {4'd0, mx};
        sy = {4'd0, my} * {4'd0, my};
        return {1'b0, sx} + {1'b0, sy};
    endfunction

endpackage

// File: rtl/laser_cover_scorer.sv
// Counts points of one bank lying within the coverage radius of either center.
// Ports: start pulse, centers, point read port (rd_addr/px/py), score/valid, last.
module laser_cover_scorer
    import laser_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  coord_t     c1x,
    input  coord_t     c1y,
    input  coord_t     c2x,
    input  coord_t     c2y,
    output logic [5:0] rd_addr,
    input  coord_t     px,
    input  coord_t     py,
    output logic [5:0] score,
    output logic       valid,
    output logic       last
);

    logic       busy;
    logic [5:0] cnt;
    logic [5:0] acc;
    logic       active;
    logic       hit;
    logic [5:0] acc_nxt;

    // Point 0 is evaluated in the start cycle itself.
    assign active  = start | busy;
    assign rd_addr = busy ? cnt : 6'd0;
    assign hit     = (dist_sq(px, py, c1x, c1y) <= RADIUS_SQ)
                   | (dist_sq(px, py, c2x, c2y) <= RADIUS_SQ);
    assign acc_nxt = (busy ? acc : 6'd0) + {5'd0, hit};
    assign last    = active && (rd_addr == LAST_IDX);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy  <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            score <= '0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (active) begin
                if (last) begin
                    score <= acc_nxt;
                    valid <= 1'b1;
                    busy  <= 1'b0;
                end else begin
                    busy <= 1'b1;
                    cnt  <= rd_addr + 6'd1;
                    acc  <= acc_nxt;
                end
            end
        end
    end

endmodule

// File: rtl/laser_target_feeder.sv
// Ping-pong image feeder for the two-circle laser engine, with result re-scoring.
// Ports: WR_* fill side, X/Y/LASER_RST stream side, DONE_IN/C*_IN results, SCORE and error flags.
module laser_target_feeder
    import laser_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       WR_EN,
    input  logic [5:0] WR_ADDR,
    input  logic [3:0] WR_X,
    input  logic [3:0] WR_Y,
    input  logic       WR_COMMIT,
    output logic       FILL_READY,
    output logic       LASER_RST,
    output logic [3:0] X,
    output logic [3:0] Y,
    input  logic       DONE_IN,
    input  logic [3:0] C1X_IN,
    input  logic [3:0] C1Y_IN,
    input  logic [3:0] C2X_IN,
    input  logic [3:0] C2Y_IN,
    output logic [3:0] C1X,
    output logic [3:0] C1Y,
    output logic [3:0] C2X,
    output logic [3:0] C2Y,
    output logic [5:0] SCORE,
    output logic       SCORE_VALID,
    output logic       UNDERRUN_ERR,
    output logic       TIMEOUT_ERR
);

    coord_t   mem_x [2][NPTS];
    coord_t   mem_y [2][NPTS];
    bank_st_t bank_st [2];
    strm_st_t sst;

    logic       fill_ptr;
    logic       strm_ptr;
    logic       score_bank;
    logic       score_go;
    logic [5:0] idx;
    logic [9:0] wcnt;
    logic       wr_ok;
    logic       commit_ok;
    logic       next_ready;
    logic       start_now;
    logic [5:0] sc_addr;
    logic       sc_last;
    coord_t     sc_px;
    coord_t     sc_py;

    assign FILL_READY = (bank_st[fill_ptr] == B_FREE);
    assign wr_ok      = WR_EN && FILL_READY && (WR_ADDR < 6'(NPTS));
    assign commit_ok  = WR_COMMIT && FILL_READY;
    assign next_ready = (bank_st[~strm_ptr] == B_READY);
    // A commit into the stream bank starts it at the same edge.
    assign start_now  = (bank_st[strm_ptr] == B_READY)
                      || (commit_ok && (fill_ptr == strm_ptr));

    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            mem_x[fill_ptr][WR_ADDR] <= WR_X;
            mem_y[fill_ptr][WR_ADDR] <= WR_Y;
        end
    end

    // DONE_IN reaches X/Y only when the next bank can start immediately.
    always_comb begin
        X = '0;
        Y = '0;
        if (sst == S_STREAM) begin
            X = mem_x[strm_ptr][idx];
            Y = mem_y[strm_ptr][idx];
        end else if (sst == S_WAIT && DONE_IN && next_ready) begin
            X = mem_x[~strm_ptr][0];
            Y = mem_y[~strm_ptr][0];
        end
    end

    assign sc_px = mem_x[score_bank][sc_addr];
    assign sc_py = mem_y[score_bank][sc_addr];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bank_st[0]   <= B_FREE;
            bank_st[1]   <= B_FREE;
            fill_ptr     <= 1'b0;
            strm_ptr     <= 1'b0;
            score_bank   <= 1'b0;
            score_go     <= 1'b0;
            sst          <= S_HOLD;
            idx          <= '0;
            wcnt         <= '0;
            LASER_RST    <= 1'b1;
            C1X          <= '0;
            C1Y          <= '0;
            C2X          <= '0;
            C2Y          <= '0;
            UNDERRUN_ERR <= 1'b0;
            TIMEOUT_ERR  <= 1'b0;
        end else begin
            score_go <= 1'b0;
            if (commit_ok) begin
                bank_st[fill_ptr] <= B_READY;
                fill_ptr          <= ~fill_ptr;
            end
            if (sc_last) begin
                bank_st[score_bank] <= B_FREE;
            end
            case (sst)
                S_HOLD: begin
                    if (start_now) begin
                        bank_st[strm_ptr] <= B_STREAMING;
                        sst               <= S_STREAM;
                        idx               <= '0;
                        LASER_RST         <= 1'b0;
                    end
                end
                S_STREAM: begin
                    if (idx == LAST_IDX) begin
                        sst  <= S_WAIT;
                        wcnt <= '0;
                    end else begin
                        idx <= idx + 6'd1;
                    end
                end
                S_WAIT: begin
                    if (DONE_IN) begin
                        C1X               <= C1X_IN;
                        C1Y               <= C1Y_IN;
                        C2X               <= C2X_IN;
                        C2Y               <= C2Y_IN;
                        bank_st[strm_ptr] <= B_SCORING;
                        score_bank        <= strm_ptr;
                        score_go          <= 1'b1;
                        strm_ptr          <= ~strm_ptr;
                        if (next_ready) begin
                            bank_st[~strm_ptr] <= B_STREAMING;
                            sst                <= S_STREAM;
                            idx                <= 6'd1;
                        end else begin
                            UNDERRUN_ERR <= 1'b1;
                            sst          <= S_HOLD;
                            LASER_RST    <= 1'b1;
                        end
                    end else if (wcnt == TIMEOUT) begin
                        TIMEOUT_ERR       <= 1'b1;
                        bank_st[strm_ptr] <= B_FREE;
                        strm_ptr          <= ~strm_ptr;
                        sst               <= S_HOLD;
                        LASER_RST         <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 10'd1;
                    end
                end
                default: sst <= S_HOLD;
            endcase
        end
    end

    laser_cover_scorer u_scorer (
        .CLK     (CLK),
        .RST     (RST),
        .start   (score_go),
        .c1x     (C1X),
        .c1y     (C1Y),
        .c2x     (C2X),
        .c2y     (C2Y),
        .rd_addr (sc_addr),
        .px      (sc_px),
        .py      (sc_py),
        .score   (SCORE),
        .valid   (SCORE_VALID),
        .last    (sc_last)
    );

endmodule

// File: tb/tb_laser_target_feeder.sv
// Directed bench for laser_target_feeder: streaming, scoring, underrun, timeout, reset.
// Drives the fill and engine sides and checks outputs one cycle at a time.
module tb_laser_target_feeder;

    logic       CLK;
    logic       RST;
    logic       WR_EN;
    logic [5:0] WR_ADDR;
    logic [3:0] WR_X;
    logic [3:0] WR_Y;
    logic       WR_COMMIT;
    logic       FILL_READY;
    logic       LASER_RST;
    logic [3:0] X;
    logic [3:0] Y;
    logic       DONE_IN;
    logic [3:0] C1X_IN;
    logic [3:0] C1Y_IN;
    logic [3:0] C2X_IN;
    logic [3:0] C2Y_IN;
    logic [3:0] C1X;
    logic [3:0] C1Y;
    logic [3:0] C2X;
    logic [3:0] C2Y;
    logic [5:0] SCORE;
    logic       SCORE_VALID;
    logic       UNDERRUN_ERR;
    logic       TIMEOUT_ERR;

    int n_chk = 0;
    int n_fail = 0;
    logic sv_seen;

    laser_target_feeder dut (
        .CLK          (CLK),
        .RST          (RST),
        .WR_EN        (WR_EN),
        .WR_ADDR      (WR_ADDR),
        .WR_X         (WR_X),
        .WR_Y         (WR_Y),
        .WR_COMMIT    (WR_COMMIT),
        .FILL_READY   (FILL_READY),
        .LASER_RST    (LASER_RST),
        .X            (X),
        .Y            (Y),
        .DONE_IN      (DONE_IN),
        .C1X_IN       (C1X_IN),
        .C1Y_IN       (C1Y_IN),
        .C2X_IN       (C2X_IN),
        .C2Y_IN       (C2Y_IN),
        .C1X          (C1X),
        .C1Y          (C1Y),
        .C2X          (C2X),
        .C2Y          (C2Y),
        .SCORE        (SCORE),
        .SCORE_VALID  (SCORE_VALID),
        .UNDERRUN_ERR (UNDERRUN_ERR),
        .TIMEOUT_ERR  (TIMEOUT_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Image patterns: 0 = all (8,8); 1 = boundary pair then (x, 15-x), x = i mod 16.
    // With both centers at (8,8), pattern 1 covers point 0 and x in 5..10: 16 points.
    function automatic logic [7:0] pt(input int sel, input int i);
        logic [3:0] x;
        if (sel == 0) return 8'h88;
        if (i == 0) return {4'd12, 4'd8};
        if (i == 1) return {4'd11, 4'd11};
        x = 4'(i % 16);
        return {x, 4'd15 - x};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ends one cycle after the commit edge.
    task automatic write_img(input int sel);
        for (int i = 0; i < 40; i++) begin
            WR_EN = 1'b1;
            WR_ADDR = 6'(i);
            {WR_X, WR_Y} = pt(sel, i);
            tick();
        end
        WR_EN = 1'b0;
        WR_COMMIT = 1'b1;
        tick();
        WR_COMMIT = 1'b0;
    endtask

    task automatic stream_chk(input int sel, input int from);
        for (int k = from; k < 40; k++) begin
            chk($sformatf("stream%0d_p%0d", sel, k), {X, Y, LASER_RST}, {pt(sel, k), 1'b0});
            tick();
        end
    endtask

    initial begin
        RST = 1'b1;
        WR_EN = 1'b0;
        WR_ADDR = '0;
        WR_X = '0;
        WR_Y = '0;
        WR_COMMIT = 1'b0;
        DONE_IN = 1'b0;
        C1X_IN = '0;
        C1Y_IN = '0;
        C2X_IN = '0;
        C2Y_IN = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_lrst_fill", {LASER_RST, FILL_READY}, 2'b11);
        chk("rst_xy", {X, Y}, 8'h00);
        chk("rst_centers", {C1X, C1Y, C2X, C2Y}, 16'h0000);
        chk("rst_score", {SCORE_VALID, SCORE}, 7'd0);
        chk("rst_errs", {UNDERRUN_ERR, TIMEOUT_ERR}, 2'b00);
        RST = 1'b0;
        tick();

        // First image into bank 0: streams straight after commit.
        write_img(0);
        stream_chk(0, 0);
        chk("a_after_xy", {X, Y, LASER_RST}, 9'd0);

        // Bank 1 loaded while engine works; DONE after 100 wait cycles.
        write_img(1);
        repeat (59) tick();
        DONE_IN = 1'b1;
        C1X_IN = 4'd8;
        C1Y_IN = 4'd8;
        C2X_IN = 4'd0;
        C2Y_IN = 4'd0;
        #1;
        chk("b2b_p0_comb", {X, Y, LASER_RST}, {pt(1, 0), 1'b0});
        tick();
        DONE_IN = 1'b0;
        chk("a_capture", {C1X, C1Y, C2X, C2Y}, 16'h8800);
        stream_chk(1, 1);
        chk("a_pre_valid", {SCORE_VALID, FILL_READY}, 2'b00);
        chk("b_after_xy", {X, Y}, 8'h00);
        tick();
        chk("a_score", {SCORE_VALID, SCORE}, {1'b1, 6'd40});
        chk("a_bank_free", FILL_READY, 1'b1);
        tick();
        chk("a_valid_pulse", SCORE_VALID, 1'b0);

        // Underrun: no bank ready at DONE.
        DONE_IN = 1'b1;
        C1X_IN = 4'd8;
        C1Y_IN = 4'd8;
        C2X_IN = 4'd8;
        C2Y_IN = 4'd8;
        #1;
        chk("ur_xy_comb", {X, Y}, 8'h00);
        tick();
        DONE_IN = 1'b0;
        chk("ur_flag_lrst", {UNDERRUN_ERR, LASER_RST}, 2'b11);
        repeat (39) tick();
        chk("b_pre_valid", SCORE_VALID, 1'b0);
        tick();
        chk("b_score", {SCORE_VALID, SCORE}, {1'b1, 6'd16});

        // Restart after underrun.
        write_img(1);
        stream_chk(1, 0);
        chk("c_after_xy", {X, Y}, 8'h00);

        // Timeout: bank 1 is ready, bank 0 never gets DONE.
        write_img(0);
        sv_seen = 1'b0;
        repeat (982) begin
            tick();
            sv_seen = sv_seen | SCORE_VALID;
        end
        chk("to_before", {TIMEOUT_ERR, FILL_READY}, 2'b00);
        tick();
        chk("to_flag", {TIMEOUT_ERR, FILL_READY, LASER_RST, UNDERRUN_ERR}, 4'b1111);
        chk("to_no_score", sv_seen | SCORE_VALID, 1'b0);
        tick();
        chk("to_next_p0", {X, Y, LASER_RST}, {8'h88, 1'b0});
        repeat (20) tick();
        chk("pre_rst_p20", {X, Y, LASER_RST}, {8'h88, 1'b0});

        // Asynchronous reset mid-stream.
        #2;
        RST = 1'b1;
        #1;
        chk("mrst_xy_lrst", {X, Y, LASER_RST}, 9'd1);
        chk("mrst_flags", {UNDERRUN_ERR, TIMEOUT_ERR, SCORE_VALID}, 3'b000);
        chk("mrst_score", {SCORE, C1X}, 10'd0);
        tick();
        tick();
        RST = 1'b0;
        repeat (5) tick();
        chk("post_rst_idle", {FILL_READY, LASER_RST, X, Y}, {2'b11, 8'h00});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/laser_target_feeder.md
# laser_target_feeder

Host-side counterpart of the two-circle laser coverage engine. It holds up to two 40-point images in ping-pong banks and releases the engine from reset once the first image is committed. It then streams each image on X/Y at one point per cycle with the exact framing the engine samples. On each DONE it captures the returned circle centers and independently re-scores how many points lie within radius 4 of either center.

## Interface
- NPTS, 40: points per image
- RADIUS_SQ, 16: inclusive coverage threshold on dx²+dy²
- TIMEOUT, 1023: max cycles in WAIT_DONE before abort
- CLK  in  1  clock
- RST  in  1  reset; RST, asynchronous, active-high; clock CLK
- WR_EN  in  1  write point into current fill bank
- WR_ADDR  in  6  point index 0..NPTS-1; writes with WR_ADDR≥NPTS are ignored
- WR_X, WR_Y  in  4 each  point coordinates
- WR_COMMIT  in  1  marks fill bank READY; toggles fill pointer
- FILL_READY  out  1  fill bank is FREE and accepts writes/commit
- LASER_RST  out  1  reset driven to the engine
- X, Y  out  4 each  streamed point (combinational)
- DONE_IN  in  1  engine done strobe
- C1X_IN, C1Y_IN, C2X_IN, C2Y_IN  in  4 each  engine result
- C1X, C1Y, C2X, C2Y  out  4 each  captured result
- SCORE  out  6  covered-point count
- SCORE_VALID  out  1  one-cycle strobe
- UNDERRUN_ERR, TIMEOUT_ERR  out  1 each  sticky error flags

## Operation
- Each bank has a state: FREE, READY, STREAMING or SCORING. Reset sets both banks FREE and clears both pointers to bank 0. Memory contents are not reset.
- Writes and commits are accepted only when FILL_READY=1 and are otherwise dropped. A commit sets the bank READY and moves the fill pointer to the other bank.
- Stream FSM states: HOLD, STREAM, WAIT_DONE.
  - HOLD: LASER_RST=1 and X=Y=0. When the stream bank is READY, the FSM goes to STREAM with idx=0 and LASER_RST is deasserted at that edge.
  - STREAM: X/Y = bank[idx], with idx advancing 0..NPTS-1. After idx NPTS-1 the FSM goes to WAIT_DONE, X=Y=0, and the wait counter is cleared.
  - WAIT_DONE, on DONE_IN=1:
    - Capture C*_IN into C* and hand the bank to the scorer (SCORING).
    - Toggle the stream pointer.
    - If the new stream bank is READY, X/Y show its point 0 in this same cycle and the FSM goes to STREAM with idx=1.
    - Otherwise set UNDERRUN_ERR and go to HOLD with LASER_RST=1 next cycle.
  - WAIT_DONE, on wait counter = TIMEOUT without DONE_IN: set TIMEOUT_ERR, free the bank without scoring, toggle the stream pointer, and go to HOLD.
- Scorer: runs for NPTS cycles, evaluating one point per cycle against the captured centers.
  - dx, dy are 5-bit signed exact differences.
  - d² = dx²+dy² is 9-bit unsigned.
  - A point is counted if d² ≤ RADIUS_SQ for C1 or for C2.
  - On completion SCORE is updated, SCORE_VALID pulses, and the bank becomes FREE.
- DONE_IN outside WAIT_DONE is ignored.
- Reset mid-operation: all state is aborted, LASER_RST=1, flags are cleared, and any partially written bank is discarded.

## Timing
- Reset values:
  - LASER_RST=1, FILL_READY=1, X=Y=0.
  - C*=0, SCORE=0, SCORE_VALID=0, both error flags 0.
- First image:
  - Point 0 appears in the first cycle with LASER_RST=0, which is the cycle after the commit edge.
  - Point i appears i cycles later.
  - Exactly NPTS consecutive points, with no gaps.
- Back-to-back images: point 0 of image k+1 is driven combinationally in the DONE_IN cycle, and point i is driven i cycles after it. DONE_IN→X/Y is the only combinational path.
- Scoring starts the cycle after the DONE_IN capture. SCORE_VALID is high NPTS+1 cycles after DONE_IN.
- The engine needs more than 2·NPTS cycles between DONEs, so scoring never overlaps a second capture.
- A commit in the same cycle that a bank becomes FREE is legal; the freed bank reports FILL_READY from the next cycle.

## Structure
- Package laser_pkg:
  - NPTS and RADIUS_SQ constants.
  - 4-bit coordinate type.
  - Bank-state enum (FREE/READY/STREAMING/SCORING).
  - Stream-state enum (HOLD/STREAM/WAIT_DONE).
- Sub-module laser_cover_scorer: point RAM read port in, two centers in, start/valid handshake, 6-bit count out.

## Test plan
- Load 40×(8,8), commit:
  - LASER_RST falls next cycle.
  - X=8, Y=8 for exactly 40 cycles, then 0.
  - DONE_IN with C1=(8,8), C2=(0,0) → SCORE=40 at DONE+41.
- Boundary scoring: points (12,8) and (11,11) with C1=C2=(8,8) → first counted (d²=16), second not (d²=18).
- Two banks committed, DONE_IN pulses after 100 cycles → bank 1 point 0 on X/Y in the DONE cycle, points 1..39 follow with no gap.
- Only one bank committed, DONE_IN arrives → UNDERRUN_ERR=1, LASER_RST=1 next cycle; later commit restarts streaming at point 0.
- No DONE_IN for TIMEOUT cycles → TIMEOUT_ERR=1, no SCORE_VALID, bank FREE (FILL_READY=1).
- RST asserted at stream idx 20 → X=Y=0 and LASER_RST=1 immediately; after release, FILL_READY=1 and no stream until a new commit.
